product_accumulator: RTL
========================

# product_accumulator

Streaming accumulator that sits directly downstream of the 4x3 `product` multiplier. It consumes 7-bit products over a valid/ready handshake, sums up to `LEN` of them per frame into a saturating `ACC_W`-bit accumulator, and emits one registered frame result with sum, beat count and overflow flag. Frames close on the `LEN`-th beat, on `in_last`, or on `flush`.

## Interface
- `LEN`, 8: maximum number of products per frame; must be ≥1.
- `ACC_W`, 10: accumulator width; must be ≥7.
- `CNT_W`, `$clog2(LEN+1)`: width of the beat count (derived, not overridden).

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  product beat valid.
- `in_ready`  out  1  block accepts a beat this cycle.
- `in_data`  in  7  unsigned product (0..105).
- `in_last`  in  1  beat is the final one of the frame; qualified by `in_valid`.
- `flush`  in  1  close a partial frame; level-sampled.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  consumer takes the result.
- `out_sum`  out  `ACC_W`  saturated frame sum.
- `out_count`  out  `CNT_W`  beats in the frame (1..`LEN`).
- `out_ovf`  out  1  the sum saturated at least once during the frame.

## Operation
- There are two states, ACC and HOLD. Reset enters ACC with `acc`=0, `cnt`=0 and `ovf`=0.
- `in_ready` = (state==ACC) & ~`rst`. It has no combinational dependence on `out_ready`.
- **Accept:** a beat is accepted when `in_valid`&`in_ready` at a clock edge.
  - `acc` ← sat(`acc` + zero-extended `in_data`).
  - `cnt` ← `cnt`+1.
  - `ovf` ← `ovf` | saturated.
- **Saturation:** if the true sum is ≥2^`ACC_W`, the result is all ones and the saturated flag is set. Once saturated, the accumulator stays at all ones.
- **Frame close (ACC→HOLD):** the frame closes on any of:
  - an accepted beat with `cnt`+1==`LEN`;
  - an accepted beat with `in_last`=1;
  - `flush`=1 with `cnt`>0 and no accepted beat.
- **On close:**
  - `out_sum`, `out_count` and `out_ovf` load the post-update values.
  - `acc`, `cnt` and `ovf` clear.
  - `out_valid`←1.
- **Flush interactions:**
  - `flush` with an accepted beat in the same cycle: the beat is included and the frame closes.
  - `flush` with `cnt`==0 and no beat: ignored, no output.
  - `flush` in HOLD: ignored.
- **HOLD:**
  - `out_*` stay stable and `in_ready`=0.
  - When `out_valid`&`out_ready` at an edge: `out_valid`←0 and the state returns to ACC.
  - `out_sum`, `out_count` and `out_ovf` keep their last values after the handshake.
- **Reset mid-frame:** asserting `rst` discards the partial frame and any held result. All outputs go to their reset values immediately.
- **Reset values:**
  - `out_valid`=0, `out_sum`=0, `out_count`=0, `out_ovf`=0.
  - `in_ready`=0 while `rst` is asserted, and 1 in the first cycle after deassertion.

## Timing
- The closing beat is accepted at edge k; `out_valid`=1 from edge k until the consuming edge.
- When `out_ready` is held high, `in_ready` is low for exactly one cycle per frame, giving a minimum period of `LEN`+1 cycles per frame.
- Back-to-back beats in ACC are accepted every cycle.
- All outputs except `in_ready` are driven directly from flops.

## Structure
- **Shared package:**
  - `PROD_W`=7, the product width matching the multiplier output;
  - the state enum {ACC, HOLD}.
- **Sub-module:** `sat_adder`, a combinational `ACC_W`-bit saturating adder with output `sum` and flag `sat`, instantiated once.

## Test plan
All scenarios use `LEN`=4 and `ACC_W`=10 unless noted.
1. Beats 105,105,105,105 back-to-back, `out_ready`=1 → `out_valid` one cycle after the 4th accept; `out_sum`=420, `out_count`=4, `out_ovf`=0; `in_ready` low for exactly 1 cycle.
2. `ACC_W`=8: beats 105,105,105,0 → `out_sum`=255, `out_ovf`=1, `out_count`=4.
3. Beats 10, then 20 with `in_last` → `out_sum`=30, `out_count`=2; the next frame starts from 0.
4. Beats 1,2,3, then `flush` with no beat → `out_sum`=6, `out_count`=3 next cycle. A second `flush` with `cnt`=0 → no `out_valid`. `flush` with a beat of 4 in the same cycle → the next frame closes with sum 4, count 1.
5. Hold `out_ready`=0 for 5 cycles after a close, with `in_valid`=1 and data 9 held → `out_*` stable and `in_ready`=0. Raising `out_ready` → the handshake completes, and the held 9 is accepted on the next edge.
6. Assert `rst` after beats 50,50 → all outputs 0 asynchronously. After release, beats 7,7,7,7 → `out_sum`=28, `out_count`=4.

Source files
------------

// File: rtl/product_accumulator_pkg.sv
// Shared types and constants for the product accumulator slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   PROD_W  - width of one product from the 4x3 multiplier (max 15*7 = 105)
//   state_t - frame FSM states: ACC (collecting beats) and HOLD (result held)
package product_accumulator_pkg;

    // Output width of the upstream 4x3 multiplier.
    localparam int PROD_W = 7;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage : product_accumulator_pkg

// File: rtl/product_accumulator_sat_adder.sv
// Saturating unsigned adder: sum clamps to all ones when the true sum overflows.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the inputs.
//
// Ports:
//   a    in  W  accumulator operand
//   b    in  W  addend (caller zero-extends narrower operands)
//   sum  out W  min(a + b, 2^W - 1)
//   sat  out 1  the true sum did not fit in W bits
module sat_adder #(
    parameter int W = 10
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         sat
);

    // One extra bit catches the carry out; that carry is the overflow indication.
    logic [W:0] full_sum;

    assign full_sum = {1'b0, a} + {1'b0, b};
    assign sat      = full_sum[W];
    assign sum      = full_sum[W] ? {W{1'b1}} : full_sum[W-1:0];

endmodule : sat_adder

// File: rtl/product_accumulator.sv
// Frame accumulator for multiplier products: sums up to LEN beats per frame into a saturating register.
// Latency: result registered on the closing edge (beat, in_last or flush); out_valid visible right after it.
// Backpressure: in_ready drops for the whole HOLD phase; it is released by the out_valid/out_ready handshake.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      product beat valid
//   in_ready   out  1      beat accepted this cycle (ACC state and not in reset)
//   in_data    in   7      unsigned product
//   in_last    in   1      final beat of the frame (qualified by in_valid)
//   flush      in   1      close a non-empty partial frame (level-sampled)
//   out_valid  out  1      frame result valid
//   out_ready  in   1      consumer takes the result
//   out_sum    out  ACC_W  saturated frame sum
//   out_count  out  CNT_W  beats in the frame
//   out_ovf    out  1      saturation occurred during the frame
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int LEN   = 8,
    parameter int ACC_W = 10,
    parameter int CNT_W = $clog2(LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_data,
    input  logic              in_last,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q;
    state_t             state_d;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;

    // ------------------------------------------------------------------
    // Beat-level signals
    // ------------------------------------------------------------------
    logic               accept;
    logic               close;
    logic [ACC_W-1:0]   add_b;
    logic [ACC_W-1:0]   add_sum;
    logic               add_sat;
    logic [CNT_W-1:0]   cnt_inc;

    // Post-update frame values: what the frame looks like after this edge,
    // whether or not a beat is taken. Loaded into out_* on close.
    logic [ACC_W-1:0]   acc_next;
    logic [CNT_W-1:0]   cnt_next;
    logic               ovf_next;

    // in_ready deliberately ignores out_ready so that no combinational path
    // runs from the consumer back to the producer.
    assign in_ready = (state_q == ACC) & ~rst;
    assign accept   = in_valid & in_ready;

    assign add_b    = ACC_W'(in_data);
    assign cnt_inc  = cnt_q + 1'b1;

    sat_adder #(
        .W (ACC_W)
    ) u_sat_adder (
        .a   (acc_q),
        .b   (add_b),
        .sum (add_sum),
        .sat (add_sat)
    );

    always_comb begin
        acc_next = acc_q;
        cnt_next = cnt_q;
        ovf_next = ovf_q;
        if (accept) begin
            acc_next = add_sum;
            cnt_next = cnt_inc;
            ovf_next = ovf_q | add_sat;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: next state and close decision
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        close   = 1'b0;
        unique case (state_q)
            ACC: begin
                if (accept) begin
                    // A flush arriving with a beat adds nothing beyond the
                    // close itself; the beat is always included.
                    close = (cnt_inc == LEN_C) | in_last | flush;
                end else begin
                    // An empty frame has nothing to report, so flush is dropped.
                    close = flush & (cnt_q != '0);
                end
                if (close) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_valid && out_ready) begin
                    state_d = ACC;
                end
            end
            default: begin
                state_d = ACC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Running frame accumulator
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (close) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_next;
            cnt_q <= cnt_next;
            ovf_q <= ovf_next;
        end
    end

    // ------------------------------------------------------------------
    // Result registers: loaded only on close, so they keep the previous
    // frame's result after the handshake until the next close.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (close) begin
            out_valid <= 1'b1;
            out_sum   <= acc_next;
            out_count <= cnt_next;
            out_ovf   <= ovf_next;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule : product_accumulator
